// File: rtl/aes_key_schedule.sv
// Sequential AES key expansion for 128/192/256-bit keys: one schedule word per clock,
// with the full schedule stored for random-access round-key readout.

module aes_sbox_word (
  input  logic [31:0] col,
  output logic [31:0] sub_col
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0, then the AES affine step
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv;
    logic [7:0] sq;
    inv = 8'h01;
    sq  = a;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  always_comb begin
    sub_col = '0;
    for (int k = 0; k < 4; k++) sub_col[8*k +: 8] = sbox(col[8*k +: 8]);
  end

endmodule

module aes_key_schedule #(
  parameter int KEY_BITS = 128
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [255:0] key_in,
  output logic         busy,
  output logic         ready,
  output logic [3:0]   nr,
  input  logic         rd_en,
  input  logic [3:0]   rd_round,
  output logic [127:0] rd_key,
  output logic         rd_valid
);

  localparam int NK = KEY_BITS / 32;
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_EXPAND = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("aes_key_schedule: KEY_BITS must be 128, 192 or 256");
  end

  logic [1:0]  state;
  logic [5:0]  idx;
  logic [2:0]  phase;
  logic [7:0]  rcon;
  logic [31:0] win [NK];
  logic [31:0] sched [NW];

  logic        accept;
  logic        last;
  logic        rd_ok;
  logic [31:0] prev;
  logic [31:0] sbox_in;
  logic [31:0] sbox_out;
  logic [31:0] temp;
  logic [31:0] new_word;
  logic [5:0]  base;
  logic        unused_key;

  assign accept     = start && (state == S_IDLE || state == S_DONE);
  assign last       = (idx == 6'(NW - 1));
  assign prev       = win[NK-1];
  assign sbox_in    = (phase == 3'd0) ? {prev[23:0], prev[31:24]} : prev;
  assign new_word   = win[0] ^ temp;
  assign rd_ok      = rd_en && ready && !start && (rd_round <= 4'(NR));
  assign base       = {rd_round, 2'b00};
  assign nr         = 4'(NR);
  assign unused_key = ^key_in;

  aes_sbox_word u_sbox (
    .col     (sbox_in),
    .sub_col (sbox_out)
  );

  // phase tracks i mod Nk so no divider is needed
  always_comb begin
    temp = prev;
    if (phase == 3'd0) temp = sbox_out ^ {rcon, 24'h000000};
    else if (NK == 8 && phase == 3'd4) temp = sbox_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      idx   <= '0;
      phase <= '0;
      rcon  <= '0;
      busy  <= 1'b0;
      ready <= 1'b0;
    end else begin
      busy  <= (state == S_LOAD) || (state == S_EXPAND);
      ready <= (state == S_DONE) && !accept;
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            state <= S_LOAD;
            idx   <= 6'(NK);
            phase <= '0;
            rcon  <= 8'h01;
          end
        end
        S_LOAD: state <= S_EXPAND;
        S_EXPAND: begin
          idx   <= idx + 6'd1;
          phase <= (phase == 3'(NK - 1)) ? 3'd0 : phase + 3'd1;
          if (phase == 3'd0) rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
          if (last) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // window holds w[i-Nk..i-1]; storage is write-only during expansion
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int j = 0; j < NK; j++) win[j] <= key_in[255 - 32*j -: 32];
    end else if (state == S_LOAD) begin
      for (int j = 0; j < NK; j++) sched[j] <= win[j];
    end else if (state == S_EXPAND) begin
      for (int j = 0; j < NK - 1; j++) win[j] <= win[j+1];
      win[NK-1]  <= new_word;
      sched[idx] <= new_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_key   <= '0;
    end else if (rd_en) begin
      rd_valid <= rd_ok;
      rd_key   <= rd_ok ? {sched[base], sched[base + 6'd1], sched[base + 6'd2], sched[base + 6'd3]}
                        : '0;
    end
  end

endmodule

// File: tb/tb_aes_key_schedule.sv
// Bench for aes_key_schedule: all three key sizes side by side, checked every cycle
// against an array-based FIPS-197 expansion model plus known-answer vectors.

module tb_aes_key_schedule;

  localparam logic [127:0] K128     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] R1_128   = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] R10_128  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [191:0] K192     = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [127:0] R12_192  = 128'he98ba06f448c773c8ecc720401002202;
  localparam logic [255:0] K256     = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] R14_256  = 128'hfe4890d1e6188d0b046df344706c631e;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         rd_en = 1'b0;
  logic [3:0]   rd_round = 4'd0;
  logic [255:0] key_w [3];
  logic         busy_w [3];
  logic         ready_w [3];
  logic         rd_valid_w [3];
  logic [3:0]   nr_w [3];
  logic [127:0] rd_key_w [3];

  int total = 0;
  int bad = 0;
  int rise [3];
  int exp_lat [3] = '{42, 48, 54};

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    aes_key_schedule #(.KEY_BITS(128 + 64*g)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .key_in   (key_w[g]),
      .busy     (busy_w[g]),
      .ready    (ready_w[g]),
      .nr       (nr_w[g]),
      .rd_en    (rd_en),
      .rd_round (rd_round),
      .rd_key   (rd_key_w[g]),
      .rd_valid (rd_valid_w[g])
    );
  end

  // reference model state
  logic [7:0]   sbox_t [256];
  logic [31:0]  msched [3][60];
  int           n_edge = 0;
  int           t_acc [3];
  bit           acc_valid [3];
  logic         m_valid [3];
  logic [127:0] m_key [3];
  int           m_d;
  bit           m_run, m_rdy, m_acc;

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
    logic [15:0] d;
    d = {b, b} << k;
    return d[15:8];
  endfunction

  function automatic int nk_of(input int s);
    return 4 + 2*s;
  endfunction

  function automatic int lat_of(input int s);
    return 2 + 4*(nk_of(s) + 7) - nk_of(s);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  function automatic logic [127:0] m_round(input int s, input int r);
    return {msched[s][4*r], msched[s][4*r+1], msched[s][4*r+2], msched[s][4*r+3]};
  endfunction

  function automatic logic [255:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // S-box from log/antilog tables over generator 3
  task automatic build_sbox();
    logic [7:0] ex [256];
    int         lg [256];
    logic [7:0] x;
    logic [7:0] b;
    x = 8'h01;
    for (int i = 0; i < 255; i++) begin
      ex[i] = x;
      lg[x] = i;
      x = x ^ xt(x);
    end
    for (int a = 0; a < 256; a++) begin
      b = (a == 0) ? 8'h00 : ex[(255 - lg[a]) % 255];
      sbox_t[a] = b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    end
  endtask

  task automatic model_expand(input int s, input logic [255:0] key);
    int nk;
    logic [31:0] t;
    logic [7:0] rc;
    nk = nk_of(s);
    for (int j = 0; j < nk; j++) msched[s][j] = key[255 - 32*j -: 32];
    rc = 8'h01;
    for (int i = nk; i < 4*(nk + 7); i++) begin
      t = msched[s][i-1];
      if (i % nk == 0) begin
        t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
        rc = xt(rc);
      end else if (nk == 8 && i % nk == 4) begin
        t = sub_word(t);
      end
      msched[s][i] = msched[s][i-nk] ^ t;
    end
  endtask

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic re, input logic [3:0] rr);
    @(negedge clk);
    start    = st;
    rd_en    = re;
    rd_round = rr;
  endtask

  // model advance on every edge (or reset), then compare all outputs 1ns later
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < 3; s++) begin
        acc_valid[s] = 1'b0;
        m_valid[s]   = 1'b0;
        m_key[s]     = '0;
      end
    end else begin
      n_edge++;
      for (int s = 0; s < 3; s++) begin
        m_d   = n_edge - t_acc[s];
        m_run = acc_valid[s] && (m_d <= lat_of(s) - 1);
        m_rdy = acc_valid[s] && (m_d - 1 >= lat_of(s));
        m_acc = start && !m_run;
        if (rd_en) begin
          m_valid[s] = m_rdy && !m_acc && (int'(rd_round) <= nk_of(s) + 6);
          if (m_valid[s]) m_key[s] = m_round(s, int'(rd_round));
          else m_key[s] = '0;
        end
        if (m_acc) begin
          acc_valid[s] = 1'b1;
          t_acc[s]     = n_edge;
          model_expand(s, key_w[s]);
        end
      end
    end
    #1;
    for (int s = 0; s < 3; s++) begin
      m_d = n_edge - t_acc[s];
      checkOutput($sformatf("busy_%0d", 128 + 64*s), 128'(busy_w[s]),
                  128'(acc_valid[s] && m_d >= 1 && m_d <= lat_of(s) - 1));
      checkOutput($sformatf("ready_%0d", 128 + 64*s), 128'(ready_w[s]),
                  128'(acc_valid[s] && m_d >= lat_of(s)));
      checkOutput($sformatf("rd_valid_%0d", 128 + 64*s), 128'(rd_valid_w[s]), 128'(m_valid[s]));
      checkOutput($sformatf("rd_key_%0d", 128 + 64*s), rd_key_w[s], m_key[s]);
      checkOutput($sformatf("nr_%0d", 128 + 64*s), 128'(nr_w[s]), 128'(nk_of(s) + 6));
    end
  end

  // start an expansion and record when each size raises ready; optional second start mid-run
  task automatic wait_ready(input int restart_at);
    for (int s = 0; s < 3; s++) rise[s] = 0;
    applyStimulus(1'b1, 1'b0, 4'd0);
    @(posedge clk);
    for (int c = 1; c <= 60; c++) begin
      if (c == restart_at) begin
        applyStimulus(1'b1, 1'b1, 4'd3);
        for (int s = 0; s < 3; s++) key_w[s] = rand_key();
      end else begin
        applyStimulus(1'b0, 1'b0, 4'd0);
      end
      @(posedge clk);
      #2;
      if (c == restart_at) checkOutput("early_rd_valid", 128'(rd_valid_w[0]), 128'(0));
      for (int s = 0; s < 3; s++)
        if (ready_w[s] && rise[s] == 0) rise[s] = c;
    end
    for (int s = 0; s < 3; s++)
      checkOutput($sformatf("latency_%0d", 128 + 64*s), 128'(rise[s]), 128'(exp_lat[s]));
  endtask

  initial begin
    build_sbox();
    checkOutput("sbox_00", 128'(sbox_t[8'h00]), 128'h63);
    checkOutput("sbox_53", 128'(sbox_t[8'h53]), 128'hed);
    checkOutput("sbox_ff", 128'(sbox_t[8'hff]), 128'h16);

    key_w[0] = {K128, 128'h0};
    key_w[1] = {K192, 64'h0};
    key_w[2] = K256;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // known-answer expansion and reverse readout
    wait_ready(0);
    for (int r = 10; r >= 0; r--) begin
      applyStimulus(1'b0, 1'b1, r[3:0]);
      @(posedge clk);
      #2;
      if (r == 10) checkOutput("kat_r10_128", rd_key_w[0], R10_128);
      if (r == 1)  checkOutput("kat_r1_128", rd_key_w[0], R1_128);
      if (r == 0)  checkOutput("kat_r0_128", rd_key_w[0], K128);
    end
    applyStimulus(1'b0, 1'b1, 4'd11);
    @(posedge clk);
    #2;
    checkOutput("r11_valid_128", 128'(rd_valid_w[0]), 128'(0));
    checkOutput("r11_key_128", rd_key_w[0], 128'h0);
    applyStimulus(1'b0, 1'b1, 4'd12);
    @(posedge clk);
    #2;
    checkOutput("kat_r12_192", rd_key_w[1], R12_192);
    applyStimulus(1'b0, 1'b1, 4'd14);
    @(posedge clk);
    #2;
    checkOutput("kat_r14_256", rd_key_w[2], R14_256);

    // second start mid-expansion with a new key must be ignored
    wait_ready(11);
    applyStimulus(1'b0, 1'b1, 4'd10);
    @(posedge clk);
    #2;
    checkOutput("restart_r10_128", rd_key_w[0], R10_128);

    // reset in the middle of an expansion
    applyStimulus(1'b1, 1'b0, 4'd0);
    @(posedge clk);
    repeat (20) begin
      applyStimulus(1'b0, 1'b0, 4'd0);
      @(posedge clk);
    end
    #3 rst_n = 1'b0;
    #1;
    checkOutput("rst_busy", 128'(busy_w[0]), 128'(0));
    checkOutput("rst_ready", 128'(ready_w[0]), 128'(0));
    checkOutput("rst_rd_valid", 128'(rd_valid_w[0]), 128'(0));
    checkOutput("rst_rd_key", rd_key_w[0], 128'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int s = 0; s < 3; s++) key_w[s] = rand_key();
    wait_ready(0);
    for (int r = 0; r < 16; r++) begin
      applyStimulus(1'b0, 1'b1, r[3:0]);
    end

    // random traffic: sporadic starts, reads and key changes
    for (int it = 0; it < 500; it++) begin
      applyStimulus($urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0)
        for (int s = 0; s < 3; s++) key_w[s] = rand_key();
    end
    applyStimulus(1'b0, 1'b0, 4'd0);
    @(posedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
